// File: rtl/audio_playback_scheduler.sv
// Playback scheduler: turns mcu_48k_clk edges into FIFO pops and DAC samples, with prefill and underrun handling.
// Optional underrun statistics are compiled in when UNDERRUN_STATS_EN is defined.
module audio_playback_scheduler #(
  parameter int DATA_W      = 16,
  parameter int LEVEL_W     = 6,
  parameter int PREFILL     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk_12mhz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               mcu_48k_clk,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic [DATA_W-1:0]  fifo_data,
  input  logic               clear_stats,
  output logic               fifo_read_en,
  output logic [DATA_W-1:0]  audio_out,
  output logic               sample_valid,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   underrun_count,
  output logic               underrun_flag
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PREFILL = 2'b01,
    S_PLAY    = 2'b10
  } state_t;

  localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  state_t                 state_q;
  logic                   play_tick;
  logic                   underrun;

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mcu_48k_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

  // The FIFO is show-ahead, so the pop strobe and the capture of fifo_data share one edge.
  assign play_tick    = reset_n & enable & (state_q == S_PLAY) & tick;
  assign fifo_read_en = play_tick & ~fifo_empty;
  assign underrun     = play_tick & fifo_empty;

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      audio_out    <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable) begin
        state_q   <= S_IDLE;
        audio_out <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q   <= S_PREFILL;
            audio_out <= '0;
          end
          S_PREFILL: begin
            // A tick on the cycle the threshold is met is still played as silence.
            if (tick) begin
              sample_valid <= 1'b1;
              audio_out    <= '0;
            end
            if (fifo_level >= PREFILL_LVL) state_q <= S_PLAY;
          end
          S_PLAY: begin
            if (tick) begin
              sample_valid <= 1'b1;
              if (!fifo_empty) audio_out <= fifo_data;
              else             state_q   <= S_PREFILL;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign state_o = state_q;

`ifdef UNDERRUN_STATS_EN
  logic [CNT_W-1:0] count_q;
  logic             flag_q;

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else if (clear_stats) begin
      // Clear wins over history but not over an underrun on the same edge.
      count_q <= underrun ? CNT_W'(1) : '0;
      flag_q  <= underrun;
    end else if (underrun) begin
      if (count_q != '1) count_q <= count_q + CNT_W'(1);
      flag_q <= 1'b1;
    end
  end

  assign underrun_count = count_q;
  assign underrun_flag  = flag_q;
`else
  logic unused_stats;
  assign unused_stats   = clear_stats ^ underrun;
  assign underrun_count = '0;
  assign underrun_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Directed testbench for audio_playback_scheduler with a show-ahead FIFO model.
// Stats expectations follow UNDERRUN_STATS_EN; CNT_W is 2 to reach saturation quickly.
module tb_audio_playback_scheduler;

  localparam int DATA_W      = 16;
  localparam int LEVEL_W     = 6;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int LAT         = SYNC_STAGES + 1;
`ifdef UNDERRUN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk_12mhz = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               mcu_48k_clk = 1'b0;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic [DATA_W-1:0]  fifo_data;
  logic               clear_stats = 1'b0;
  logic               fifo_read_en;
  logic [DATA_W-1:0]  audio_out;
  logic               sample_valid;
  logic [1:0]         state_o;
  logic [CNT_W-1:0]   underrun_count;
  logic               underrun_flag;

  int tests = 0;
  int fails = 0;

  // FIFO model: writes come from the stimulus, pops follow fifo_read_en.
  logic [DATA_W-1:0] mem [256];
  logic [7:0]        wr_ptr = 8'd0;
  logic [7:0]        rd_ptr = 8'd0;
  int                reads = 0;
  int                viol = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_level = LEVEL_W'(wr_ptr - rd_ptr);
  assign fifo_data  = mem[rd_ptr];

  always #5 clk_12mhz = ~clk_12mhz;

  always @(posedge clk_12mhz) begin
    if (fifo_read_en) begin
      rd_ptr <= rd_ptr + 8'd1;
      reads  <= reads + 1;
    end
    if (fifo_read_en && fifo_empty) viol <= viol + 1;
  end

  audio_playback_scheduler #(
    .DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .PREFILL(8),
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk_12mhz(clk_12mhz), .reset_n(reset_n), .enable(enable),
    .mcu_48k_clk(mcu_48k_clk), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_data(fifo_data), .clear_stats(clear_stats), .fifo_read_en(fifo_read_en),
    .audio_out(audio_out), .sample_valid(sample_valid), .state_o(state_o),
    .underrun_count(underrun_count), .underrun_flag(underrun_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    @(negedge clk_12mhz);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // One MCU clock pulse; lat = edges until sample_valid is seen (0 if never).
  task automatic do_tick(output int lat, output logic [DATA_W-1:0] smp);
    bit found = 1'b0;
    lat = 0;
    smp = '0;
    @(negedge clk_12mhz);
    mcu_48k_clk = 1'b1;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk_12mhz);
      if (sample_valid) begin
        found = 1'b1;
        lat = i;
        smp = audio_out;
      end
    end
    mcu_48k_clk = 1'b0;
    repeat (4) @(negedge clk_12mhz);
  endtask

  initial begin
    int lat;
    int r0;
    logic [DATA_W-1:0] smp;

    // Reset with mcu_48k_clk toggling
    reset_n = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_12mhz);
      mcu_48k_clk = ~mcu_48k_clk;
    end
    @(negedge clk_12mhz);
    check("rst_state", state_o, 2'b00);
    check("rst_audio", audio_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_read", fifo_read_en, 0);
    check("rst_count", underrun_count, 0);
    check("rst_flag", underrun_flag, 0);
    mcu_48k_clk = 1'b0;
    enable = 1'b0;
    @(negedge clk_12mhz);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_12mhz);
    check("idle_after_rst", state_o, 2'b00);

    // Prefill: four silent ticks while the level climbs
    enable = 1'b1;
    @(negedge clk_12mhz);
    check("enter_prefill", state_o, 2'b01);
    for (int k = 0; k < 4; k++) begin
      do_tick(lat, smp);
      check("prefill_lat", lat, LAT);
      check("prefill_silence", smp, 0);
      push(DATA_W'(k + 1));
    end
    for (int k = 5; k <= 7; k++) push(DATA_W'(k));
    check("prefill_below_thr", state_o, 2'b01);
    push(16'd8);
    @(negedge clk_12mhz);
    check("play_after_level8", state_o, 2'b10);

    // Steady play through samples 1..10
    push(16'd9);
    push(16'd10);
    for (int k = 1; k <= 10; k++) begin
      r0 = reads;
      do_tick(lat, smp);
      check("play_sample", smp, k);
      check("play_lat", lat, LAT);
      check("play_one_read", reads - r0, 1);
    end

    // Underrun: hold last sample, back to prefill
    r0 = reads;
    do_tick(lat, smp);
    check("ur_lat", lat, LAT);
    check("ur_hold", smp, 10);
    check("ur_no_read", reads - r0, 0);
    check("ur_state", state_o, 2'b01);
    check("ur_count", underrun_count, STATS ? 1 : 0);
    check("ur_flag", underrun_flag, STATS);
    for (int k = 0; k < 8; k++) begin
      push(DATA_W'(11 + k));
      if (k < 3) begin
        do_tick(lat, smp);
        check("refill_silence", smp, 0);
      end
    end
    @(negedge clk_12mhz);
    check("replay_state", state_o, 2'b10);
    for (int k = 11; k <= 12; k++) begin
      do_tick(lat, smp);
      check("replay_sample", smp, k);
    end

    // Disable on the tick cycle
    r0 = reads;
    @(negedge clk_12mhz);
    mcu_48k_clk = 1'b1;
    repeat (2) @(negedge clk_12mhz);
    enable = 1'b0;
    #1;
    check("dis_read_gated", fifo_read_en, 0);
    @(negedge clk_12mhz);
    check("dis_state", state_o, 2'b00);
    check("dis_audio", audio_out, 0);
    check("dis_no_valid", sample_valid, 0);
    mcu_48k_clk = 1'b0;
    repeat (4) @(negedge clk_12mhz);
    check("dis_no_read", reads - r0, 0);
    enable = 1'b1;
    @(negedge clk_12mhz);
    check("reenable_prefill", state_o, 2'b01);
    push(16'd19);
    push(16'd20);
    @(negedge clk_12mhz);
    check("reenable_play", state_o, 2'b10);
    for (int k = 13; k <= 20; k++) begin
      do_tick(lat, smp);
      check("resume_sample", smp, k);
    end

    // clear_stats coincident with an underrun
    @(negedge clk_12mhz);
    mcu_48k_clk = 1'b1;
    repeat (2) @(negedge clk_12mhz);
    clear_stats = 1'b1;
    @(negedge clk_12mhz);
    clear_stats = 1'b0;
    check("clr_ur_valid", sample_valid, 1);
    check("clr_ur_hold", audio_out, 20);
    check("clr_ur_state", state_o, 2'b01);
    check("clr_ur_count", underrun_count, STATS ? 1 : 0);
    check("clr_ur_flag", underrun_flag, STATS);
    mcu_48k_clk = 1'b0;
    repeat (4) @(negedge clk_12mhz);
    clear_stats = 1'b1;
    @(negedge clk_12mhz);
    clear_stats = 1'b0;
    check("clr_count", underrun_count, 0);
    check("clr_flag", underrun_flag, 0);

    // Saturation: five underruns on a 2-bit counter
    for (int u = 1; u <= 5; u++) begin
      for (int j = 0; j < 8; j++) push(DATA_W'(100 + 8 * u + j));
      @(negedge clk_12mhz);
      for (int j = 0; j < 9; j++) do_tick(lat, smp);
      check("sat_count", underrun_count, STATS ? ((u < 3) ? u : 3) : 0);
      check("sat_flag", underrun_flag, STATS);
    end

    check("no_read_when_empty", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
